router_fifo_param: RTL

//  Parametrised, packet-aware FIFO for the router output channels; one instance per destination port.
//  - Stores each byte with its header marker (lfd_state).
//  - Tracks remaining bytes of the packet being read and reports fill level.
//  - Generalises the fixed 8-bit x 16-deep router FIFO in width and depth.
//  - Adds occupancy output and an optional error flag.

---
 rtl/router_fifo_param.sv | 124 ++++++++++++
 1 files changed

// File: rtl/router_fifo_param.sv
// Packet-aware output-channel FIFO: stores {hdr, data} per entry and counts down the packet being read.
// Latency: 1 cycle write-to-readable; dataout registered, valid the edge after an accepted read.
// Backpressure: writes dropped while full, reads dropped while empty (flags are registered state).
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   soft_reset        synchronous flush (channel timeout); beats read/write in the same cycle
//   write_enb/datain  write request with data byte; lfd_state marks the byte as a packet header
//   read_enb          read request; dataout updates one edge later
//   full/empty        occupancy == DEPTH / occupancy == 0
//   fill_level        occupancy 0..DEPTH
//   pkt_active        a packet read is in progress (remaining-byte counter non-zero)
//   err               only when ROUTER_FIFO_ERR_EN is defined: sticky overflow/underflow flag
module router_fifo_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  // Derived from DEPTH; leave at default.
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              read_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] datain,
  output logic [DATA_W-1:0] dataout,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   fill_level,
  output logic              pkt_active
`ifdef ROUTER_FIFO_ERR_EN
  ,
  output logic              err
`endif
);

  localparam logic [ADDR_W:0]   FULL_LVL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [DATA_W-2:0] CNT_ONE  = (DATA_W-1)'(1);

  // Each entry carries the header marker in its MSB above the data byte.
  logic [DATA_W:0]   mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [DATA_W-2:0] pkt_cnt;
  logic [DATA_W:0]   rd_word;
  logic              wr_acc;
  logic              rd_acc;

  assign full       = (fill_level == FULL_LVL);
  assign empty      = (fill_level == '0);
  assign pkt_active = (pkt_cnt != '0);

  // Acceptance uses only registered flags, so a read at empty never sees the
  // same-cycle write (no fall-through) and a write at full is dropped even if
  // a read frees a slot in that cycle.
  assign wr_acc  = write_enb && !full;
  assign rd_acc  = read_enb && !empty;
  assign rd_word = mem[rd_ptr];

  // Storage has no reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wr_acc && !soft_reset) begin
      mem[wr_ptr] <= {lfd_state, datain};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      pkt_cnt    <= '0;
      dataout    <= '0;
    end else if (soft_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      pkt_cnt    <= '0;
      dataout    <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end

      if (rd_acc) begin
        rd_ptr  <= rd_ptr + PTR_ONE;
        dataout <= rd_word[DATA_W-1:0];
        // Header length field counts payload bytes; +1 covers the trailing parity byte.
        // A header seen mid-packet simply reloads the counter.
        if (rd_word[DATA_W]) begin
          pkt_cnt <= {1'b0, rd_word[DATA_W-1:2]} + CNT_ONE;
        end else if (pkt_cnt != '0) begin
          pkt_cnt <= pkt_cnt - CNT_ONE;
        end
      end else if (pkt_cnt == '0) begin
        // Idle between packets drives zero; mid-packet stalls hold the last byte.
        dataout <= '0;
      end

      if (wr_acc && !rd_acc) begin
        fill_level <= fill_level + LVL_ONE;
      end else if (rd_acc && !wr_acc) begin
        fill_level <= fill_level - LVL_ONE;
      end
    end
  end

`ifdef ROUTER_FIFO_ERR_EN
  // Sticky until a reset or flush; flags requests that were refused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (soft_reset) begin
      err <= 1'b0;
    end else if ((write_enb && full) || (read_enb && empty)) begin
      err <= 1'b1;
    end
  end
`endif

endmodule
